// File: rtl/sha_const_reader.sv
`default_nettype none
// ============================================================================
// Module      : sha_const_reader
// Description : Fetches single words or bursts of up to 8 SHA-256 constants
//               from four byte-wide RAM banks and streams the 32-bit words out.
// Revision    : 1.0 - initial release
// ============================================================================
module sha_const_reader #(
    parameter int WORDS  = 72,
    parameter int AW     = 7,
    parameter int RD_LAT = 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          MEM_READY,
    input  logic          REQ,
    input  logic [AW-1:0] ADDR,
    input  logic [3:0]    LEN,
    output logic          READY,
    output logic          RAM_RE,
    output logic [AW-1:0] RAM_ADDR,
    input  logic [7:0]    RAM_DOUT_1,
    input  logic [7:0]    RAM_DOUT_2,
    input  logic [7:0]    RAM_DOUT_3,
    input  logic [7:0]    RAM_DOUT_4,
    output logic [31:0]   DATA,
    output logic          DATA_VALID,
    output logic          LAST,
    output logic          ERR
);

    localparam logic [AW:0] WORDS_LIM = (AW+1)'(WORDS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                ram_re_q, ram_re_d;
    logic [AW-1:0]       ram_addr_q, ram_addr_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [RD_LAT-1:0]   pipe_re_q, pipe_re_d;
    logic [RD_LAT-1:0]   pipe_last_q, pipe_last_d;
    logic [31:0]         data_q, data_d;
    logic                dv_q, dv_d;
    logic                last_q, last_d;
    logic                err_q, err_d;

    logic [AW:0]         req_end;
    logic                req_legal;
    logic                accept;
    logic                issue_last;
    logic                tail_re;
    logic                tail_last;

    // End index is formed one bit wider than ADDR so ADDR+LEN cannot wrap.
    assign req_end    = {1'b0, ADDR} + (AW+1)'(LEN);
    assign req_legal  = (LEN != 4'd0) && (LEN <= 4'd8) && (req_end <= WORDS_LIM);
    assign READY      = MEM_READY && (state_q == ST_IDLE);
    assign accept     = REQ && READY;
    assign issue_last = ram_re_q && (cnt_q == 3'd0);
    assign tail_re    = pipe_re_q[RD_LAT-1];
    assign tail_last  = pipe_last_q[RD_LAT-1];

    always_comb begin
        state_d     = state_q;
        ram_re_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;
        pipe_re_d   = '0;
        pipe_last_d = '0;
        data_d      = data_q;
        dv_d        = tail_re;
        last_d      = tail_re && tail_last;

        // Slot 0 captures the read the RAM samples on this edge.
        pipe_re_d[0]   = ram_re_q;
        pipe_last_d[0] = issue_last;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_re_d[i]   = pipe_re_q[i-1];
            pipe_last_d[i] = pipe_last_q[i-1];
        end

        if (tail_re) begin
            data_d = {RAM_DOUT_1, RAM_DOUT_2, RAM_DOUT_3, RAM_DOUT_4};
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_legal) begin
                        state_d    = ST_ISSUE;
                        ram_re_d   = 1'b1;
                        ram_addr_d = ADDR;
                        cnt_d      = LEN[2:0] - 3'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_DRAIN;
                end else begin
                    ram_re_d   = 1'b1;
                    ram_addr_d = ram_addr_q + AW'(1);
                    cnt_d      = cnt_q - 3'd1;
                end
            end
            ST_DRAIN: begin
                if (tail_re && tail_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Loss of MEM_READY mid-transfer discards everything still in flight.
        if ((state_q != ST_IDLE) && !MEM_READY) begin
            state_d     = ST_IDLE;
            ram_re_d    = 1'b0;
            pipe_re_d   = '0;
            pipe_last_d = '0;
            dv_d        = 1'b0;
            last_d      = 1'b0;
            data_d      = data_q;
            err_d       = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            ram_re_q    <= 1'b0;
            ram_addr_q  <= '0;
            cnt_q       <= 3'd0;
            pipe_re_q   <= '0;
            pipe_last_q <= '0;
            data_q      <= 32'd0;
            dv_q        <= 1'b0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_re_q    <= ram_re_d;
            ram_addr_q  <= ram_addr_d;
            cnt_q       <= cnt_d;
            pipe_re_q   <= pipe_re_d;
            pipe_last_q <= pipe_last_d;
            data_q      <= data_d;
            dv_q        <= dv_d;
            last_q      <= last_d;
            err_q       <= err_d;
        end
    end

    assign RAM_RE     = ram_re_q;
    assign RAM_ADDR   = ram_addr_q;
    assign DATA       = data_q;
    assign DATA_VALID = dv_q;
    assign LAST       = last_q;
    assign ERR        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sha_const_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha_const_reader
// Description : Scoreboard bench for sha_const_reader with a banked RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha_const_reader;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        MEM_READY;
    logic        REQ;
    logic [6:0]  ADDR;
    logic [3:0]  LEN;
    logic        READY;
    logic        RAM_RE;
    logic [6:0]  RAM_ADDR;
    logic [7:0]  d1 = 8'h00, d2 = 8'h00, d3 = 8'h00, d4 = 8'h00;
    logic [31:0] DATA;
    logic        DATA_VALID;
    logic        LAST;
    logic        ERR;

    typedef struct {
        logic [31:0] d;
        logic        l;
        int          c;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          re_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] tab [72];
    logic [7:0]  b1 [128];
    logic [7:0]  b2 [128];
    logic [7:0]  b3 [128];
    logic [7:0]  b4 [128];

    sha_const_reader #(.WORDS(72), .AW(7), .RD_LAT(1)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .MEM_READY  (MEM_READY),
        .REQ        (REQ),
        .ADDR       (ADDR),
        .LEN        (LEN),
        .READY      (READY),
        .RAM_RE     (RAM_RE),
        .RAM_ADDR   (RAM_ADDR),
        .RAM_DOUT_1 (d1),
        .RAM_DOUT_2 (d2),
        .RAM_DOUT_3 (d3),
        .RAM_DOUT_4 (d4),
        .DATA       (DATA),
        .DATA_VALID (DATA_VALID),
        .LAST       (LAST),
        .ERR        (ERR)
    );

    always #5 CLK = ~CLK;

    // Banked RAM with one-cycle read latency; bank 1 holds the MSB.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (RAM_RE) begin
            d1 <= b1[RAM_ADDR];
            d2 <= b2[RAM_ADDR];
            d3 <= b3[RAM_ADDR];
            d4 <= b4[RAM_ADDR];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (RST_N) begin
            if (RAM_RE) re_cnt++;
            if (ERR) err_cnt++;
            if (DATA_VALID) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", 64'(DATA_VALID), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("data", 64'(DATA), 64'(e.d));
                    chk("last", 64'(LAST), 64'(e.l));
                    chk("arrival_cycle", 64'(cyc), 64'(e.c));
                end
            end else if (LAST) begin
                chk("last_without_valid", 64'(LAST), 64'd0);
            end
        end
    end

    task automatic push_burst(input int a, input int l, input int acc);
        exp_t e;
        for (int k = 0; k < l; k++) begin
            e.d = tab[a+k];
            e.l = (k == l - 1);
            e.c = acc + 2 + k;
            sb.push_back(e);
        end
    endtask

    task automatic send(input logic [6:0] a, input logic [3:0] l, output int acc);
        int w;
        w = 0;
        @(negedge CLK);
        REQ = 1'b1; ADDR = a; LEN = l;
        #1;
        while (!READY && w < 60) begin
            @(negedge CLK);
            #1;
            w++;
        end
        chk("req_accepted", 64'(READY), 64'd1);
        acc = cyc + 1;
        if (READY) push_burst(int'(a), int'(l), acc);
        @(posedge CLK);
        #1;
        REQ = 1'b0;
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 60) begin
            @(negedge CLK);
            #1;
            w++;
        end
        chk("burst_drained", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic run(input logic [6:0] a, input logic [3:0] l);
        int e0, r0, acc;
        e0 = err_cnt;
        r0 = re_cnt;
        send(a, l, acc);
        wait_done();
        @(negedge CLK);
        #1;
        chk("ram_reads", 64'(re_cnt - r0), 64'(l));
        chk("no_err", 64'(err_cnt - e0), 64'd0);
        chk("ready_after", 64'(READY), 64'd1);
    endtask

    task automatic bad(input logic [6:0] a, input logic [3:0] l);
        int e0, r0;
        e0 = err_cnt;
        r0 = re_cnt;
        @(negedge CLK);
        REQ = 1'b1; ADDR = a; LEN = l;
        #1;
        chk("bad_ready_before", 64'(READY), 64'd1);
        @(posedge CLK);
        #1;
        REQ = 1'b0;
        @(negedge CLK);
        #1;
        chk("bad_err_pulse", 64'(ERR), 64'd1);
        chk("bad_no_re", 64'(RAM_RE), 64'd0);
        @(negedge CLK);
        #1;
        chk("bad_err_clear", 64'(ERR), 64'd0);
        chk("bad_ready_back", 64'(READY), 64'd1);
        chk("bad_no_reads", 64'(re_cnt - r0), 64'd0);
        chk("bad_err_count", 64'(err_cnt - e0), 64'd1);
    endtask

    task automatic wait_presented(input int remaining);
        int w;
        w = 0;
        while (sb.size() > remaining && w < 60) begin
            @(negedge CLK);
            #1;
            w++;
        end
        chk("burst_progress", 64'(sb.size()), 64'(remaining));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, e0, r0, acc;
        RST_N = 1'b0; MEM_READY = 1'b0; REQ = 1'b0; ADDR = '0; LEN = '0;
        tab = '{
            32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19,
            32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
            32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
            32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
            32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
            32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
            32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
            32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
            32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
        };
        for (int i = 0; i < 128; i++) begin
            b1[i] = 8'h00; b2[i] = 8'h00; b3[i] = 8'h00; b4[i] = 8'h00;
            if (i < 72) begin
                b1[i] = tab[i][31:24];
                b2[i] = tab[i][23:16];
                b3[i] = tab[i][15:8];
                b4[i] = tab[i][7:0];
            end
        end

        #1;
        chk("rst_ram_re", 64'(RAM_RE), 64'd0);
        chk("rst_ram_addr", 64'(RAM_ADDR), 64'd0);
        chk("rst_data", 64'(DATA), 64'd0);
        chk("rst_data_valid", 64'(DATA_VALID), 64'd0);
        chk("rst_last", 64'(LAST), 64'd0);
        chk("rst_err", 64'(ERR), 64'd0);
        chk("rst_ready_low", 64'(READY), 64'd0);
        MEM_READY = 1'b1;
        #1;
        chk("rst_ready_follows", 64'(READY), 64'd1);
        @(negedge CLK);
        RST_N = 1'b1;

        run(7'd0, 4'd1);
        run(7'd0, 4'd8);
        run(7'd8, 4'd1);
        run(7'd71, 4'd1);
        run(7'd64, 4'd8);

        send(7'd0, 4'd2, a1);
        send(7'd8, 4'd3, a2);
        chk("b2b_period", 64'(a2 - a1), 64'd4);
        wait_done();

        bad(7'd70, 4'd4);
        bad(7'd0, 4'd0);
        bad(7'd127, 4'd8);

        // MEM_READY gating with REQ held.
        @(negedge CLK);
        MEM_READY = 1'b0; REQ = 1'b1; ADDR = 7'd8; LEN = 4'd2;
        #1;
        chk("gate_ready_low", 64'(READY), 64'd0);
        e0 = err_cnt;
        r0 = re_cnt;
        repeat (3) @(negedge CLK);
        #1;
        chk("gate_no_reads", 64'(re_cnt - r0), 64'd0);
        chk("gate_no_err", 64'(err_cnt - e0), 64'd0);
        MEM_READY = 1'b1;
        #1;
        chk("gate_ready_high", 64'(READY), 64'd1);
        push_burst(8, 2, cyc + 1);
        @(posedge CLK);
        #1;
        REQ = 1'b0;
        wait_done();

        // MEM_READY dropped mid-burst.
        send(7'd0, 4'd8, acc);
        wait_presented(5);
        e0 = err_cnt;
        MEM_READY = 1'b0;
        @(posedge CLK);
        #1;
        sb.delete();
        @(negedge CLK);
        #1;
        chk("abort_err_pulse", 64'(ERR), 64'd1);
        chk("abort_no_valid", 64'(DATA_VALID), 64'd0);
        chk("abort_no_re", 64'(RAM_RE), 64'd0);
        chk("abort_data_hold", 64'(DATA), 64'(tab[2]));
        repeat (10) @(negedge CLK);
        #1;
        chk("abort_err_once", 64'(err_cnt - e0), 64'd1);
        MEM_READY = 1'b1;
        #1;
        chk("abort_ready_back", 64'(READY), 64'd1);

        // Reset mid-burst.
        send(7'd0, 4'd8, acc);
        wait_presented(5);
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst_data", 64'(DATA), 64'd0);
        chk("arst_data_valid", 64'(DATA_VALID), 64'd0);
        chk("arst_last", 64'(LAST), 64'd0);
        chk("arst_ram_re", 64'(RAM_RE), 64'd0);
        chk("arst_ram_addr", 64'(RAM_ADDR), 64'd0);
        chk("arst_err", 64'(ERR), 64'd0);
        sb.delete();
        r0 = re_cnt;
        @(negedge CLK);
        #1;
        RST_N = 1'b1;
        repeat (12) @(negedge CLK);
        #1;
        chk("arst_no_resume", 64'(re_cnt - r0), 64'd0);
        chk("arst_ready", 64'(READY), 64'd1);

        run(7'd71, 4'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
